// File: rtl/data_memory.sv
// 256 x 8-bit data memory with a fixed-latency IDLE/ACCESS/DONE handshake.
// BUSYWAIT stalls the CPU from the request cycle until the operation completes.
module data_memory #(
    parameter int unsigned ACCESS_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       READ,
    input  logic       WRITE,
    input  logic [7:0] ADDRESS,
    input  logic [7:0] WRITEDATA,
    output logic [7:0] READDATA,
    output logic       BUSYWAIT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       is_write_q, is_write_d;
    logic       commit;
    logic [7:0] mem_q [256];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        is_write_d = is_write_q;
        commit     = 1'b0;
        BUSYWAIT   = 1'b0;
        case (state_q)
            IDLE: begin
                BUSYWAIT = READ | WRITE;
                if (READ | WRITE) begin
                    addr_d     = ADDRESS;
                    wdata_d    = WRITEDATA;
                    is_write_d = WRITE;   // write wins when both are requested
                    count_d    = COUNT_LOAD;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                BUSYWAIT = 1'b1;
                if (count_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = DONE;
                    if (!is_write_q) begin
                        rdata_d = mem_q[addr_q];
                    end
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            DONE: begin
                // One quiet cycle so a still-held request is not taken twice.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (RESET) begin
            BUSYWAIT = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            count_q    <= 4'd0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            is_write_q <= is_write_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (commit && is_write_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign READDATA = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expected READDATA per request,
// a monitor pops on every BUSYWAIT fall and also checks the stall length.
module tb_data_memory;

    localparam int N = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       READ;
    logic       WRITE;
    logic [7:0] ADDRESS;
    logic [7:0] WRITEDATA;
    logic [7:0] READDATA;
    logic       BUSYWAIT;

    data_memory #(.ACCESS_CYCLES(N)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .READ      (READ),
        .WRITE     (WRITE),
        .ADDRESS   (ADDRESS),
        .WRITEDATA (WRITEDATA),
        .READDATA  (READDATA),
        .BUSYWAIT  (BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] ref_rd;
    logic [7:0] exp_q [$];

    task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor: a completion is the first non-reset cycle where BUSYWAIT drops.
    initial begin
        int  busy_len = 0;
        bit  prev_busy = 0;
        logic [7:0] exp;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                check_int("busywait_in_reset", int'(BUSYWAIT), 0);
                busy_len  = 0;
                prev_busy = 0;
            end else if (BUSYWAIT) begin
                busy_len++;
                prev_busy = 1;
            end else if (prev_busy) begin
                check_int("busy_length", busy_len, N + 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: got READDATA 0x%02h, required none", READDATA);
                end else begin
                    exp = exp_q.pop_front();
                    check8("readdata", READDATA, exp);
                    $display("completion: READDATA=0x%02h expected=0x%02h busy=%0d", READDATA, exp, busy_len);
                end
                busy_len  = 0;
                prev_busy = 0;
            end
        end
    end

    // Reference model: one serialized memory operation at a time.
    task automatic model_op(bit rd, bit wr, logic [7:0] a, logic [7:0] d, bit push);
        if (wr) begin
            ref_mem[a] = d;
        end else if (rd) begin
            ref_rd = ref_mem[a];
        end
        if (push) exp_q.push_back(ref_rd);
    endtask

    task automatic drive(bit rd, bit wr, logic [7:0] a, logic [7:0] d);
        @(posedge CLK);
        #1;
        READ      = rd;
        WRITE     = wr;
        ADDRESS   = a;
        WRITEDATA = d;
    endtask

    task automatic wait_done(string name);
        bit seen = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            if (!BUSYWAIT) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got BUSYWAIT stuck high, required low within 64 cycles", name);
        end
    endtask

    task automatic release_req();
        @(posedge CLK);
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    task automatic do_op(bit rd, bit wr, logic [7:0] a, logic [7:0] d);
        model_op(rd, wr, a, d, 1'b1);
        drive(rd, wr, a, d);
        wait_done("op");
        release_req();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_rd    = 8'h00;
        RESET     = 1'b1;
        READ      = 1'b1;
        WRITE     = 1'b1;
        ADDRESS   = 8'h33;
        WRITEDATA = 8'hEE;
        repeat (3) @(posedge CLK);
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check8("reset_readdata", READDATA, 8'h00);
        check_int("idle_busywait", int'(BUSYWAIT), 0);

        // Write then read
        do_op(1'b0, 1'b1, 8'h2A, 8'h5C);
        do_op(1'b1, 1'b0, 8'h2A, 8'h00);

        // Address extremes and untouched neighbour
        do_op(1'b0, 1'b1, 8'hFF, 8'hA5);
        do_op(1'b0, 1'b1, 8'h00, 8'h3C);
        do_op(1'b1, 1'b0, 8'hFF, 8'h00);
        do_op(1'b1, 1'b0, 8'h00, 8'h00);
        do_op(1'b1, 1'b0, 8'hFE, 8'h00);

        // Simultaneous READ and WRITE behaves as a write
        do_op(1'b0, 1'b1, 8'h41, 8'h12);
        do_op(1'b1, 1'b0, 8'h41, 8'h00);
        do_op(1'b1, 1'b1, 8'h40, 8'h99);
        do_op(1'b1, 1'b0, 8'h40, 8'h00);

        // Address change mid-access, then READ held through DONE
        do_op(1'b0, 1'b1, 8'h05, 8'h11);
        do_op(1'b0, 1'b1, 8'h06, 8'h22);
        model_op(1'b1, 1'b0, 8'h05, 8'h00, 1'b1);
        model_op(1'b1, 1'b0, 8'h06, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 8'h05, 8'h00);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        ADDRESS = 8'h06;
        wait_done("midchange");
        @(negedge CLK);
        check_int("back_to_back_restart", int'(BUSYWAIT), 1);
        wait_done("backtoback");
        release_req();

        // Random traffic over a small address window to force reuse
        for (int k = 0; k < 40; k++) begin
            int kind;
            logic [7:0] a;
            kind = $urandom_range(0, 2);
            a    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(248, 255)) : 8'($urandom_range(0, 7));
            do_op(kind != 1, kind != 0, a, 8'($urandom));
        end

        // Reset in the second ACCESS cycle of a write aborts it
        model_op(1'b0, 1'b1, 8'h10, 8'h77, 1'b0);
        drive(1'b0, 1'b1, 8'h10, 8'h77);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        WRITE = 1'b0;
        @(negedge CLK);
        check_int("busywait_mid_reset", int'(BUSYWAIT), 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_rd = 8'h00;
        @(negedge CLK);
        check8("readdata_after_reset", READDATA, 8'h00);
        check_int("busywait_after_reset", int'(BUSYWAIT), 0);
        do_op(1'b1, 1'b0, 8'h10, 8'h00);
        do_op(1'b1, 1'b0, 8'hFF, 8'h00);

        repeat (4) @(negedge CLK);
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
